// File: rtl/ysyx_22041071_axi_r_arb_if.sv
// Signal bundle between the two read requesters, the round-robin arbiter and the AXI read master.
interface ysyx_22041071_axi_r_arb_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ID_W   = 4
);
    logic              m0_req_valid;
    logic [ADDR_W-1:0] m0_req_addr;
    logic [LEN_W-1:0]  m0_req_len;
    logic [1:0]        m0_req_size;
    logic              m0_req_ready;
    logic              m0_rsp_valid;

    logic              m1_req_valid;
    logic [ADDR_W-1:0] m1_req_addr;
    logic [LEN_W-1:0]  m1_req_len;
    logic [1:0]        m1_req_size;
    logic              m1_req_ready;
    logic              m1_rsp_valid;

    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_resp;
    logic              rsp_last;

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ID_W-1:0]   rd_id;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic [1:0]        rd_size;
    logic              rd_resp_valid;
    logic              rd_resp_last;
    logic [DATA_W-1:0] rd_resp_data;
    logic [1:0]        rd_resp_resp;

    // Arbiter view.
    modport slave (
        input  m0_req_valid, m0_req_addr, m0_req_len, m0_req_size,
        input  m1_req_valid, m1_req_addr, m1_req_len, m1_req_size,
        output m0_req_ready, m0_rsp_valid, m1_req_ready, m1_rsp_valid,
        output rsp_data, rsp_resp, rsp_last,
        output rd_req_valid, rd_id, rd_addr, rd_len, rd_size,
        input  rd_req_ready, rd_resp_valid, rd_resp_last, rd_resp_data, rd_resp_resp
    );

    // Environment view (requesters plus read master).
    modport master (
        output m0_req_valid, m0_req_addr, m0_req_len, m0_req_size,
        output m1_req_valid, m1_req_addr, m1_req_len, m1_req_size,
        input  m0_req_ready, m0_rsp_valid, m1_req_ready, m1_rsp_valid,
        input  rsp_data, rsp_resp, rsp_last,
        input  rd_req_valid, rd_id, rd_addr, rd_len, rd_size,
        output rd_req_ready, rd_resp_valid, rd_resp_last, rd_resp_data, rd_resp_resp
    );
endinterface

// File: rtl/ysyx_22041071_axi_r_arb.sv
// Round-robin arbiter sharing one AXI read master between fetch (port 0) and load/store (port 1).
// One transaction outstanding at a time; response beats are steered combinationally to the owner.
module ysyx_22041071_axi_r_arb #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ID_W   = 4
) (
    input logic                   clk,
    input logic                   reset,
    ysyx_22041071_axi_r_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        size_q, size_d;

    logic              winner_c;
    logic              m0_req_ready_c, m1_req_ready_c;
    logic              m0_rsp_valid_c, m1_rsp_valid_c;
    logic              rd_req_valid_c;
    logic [DATA_W-1:0] rsp_data_c;

    // On a tie the port that lost last time wins; otherwise the lone requester wins.
    assign winner_c = (bus.m0_req_valid && bus.m1_req_valid) ? ~last_grant_q : bus.m1_req_valid;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        len_d          = len_q;
        size_d         = size_q;
        m0_req_ready_c = 1'b0;
        m1_req_ready_c = 1'b0;
        m0_rsp_valid_c = 1'b0;
        m1_rsp_valid_c = 1'b0;
        rd_req_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m0_req_valid || bus.m1_req_valid) begin
                    m0_req_ready_c = ~winner_c;
                    m1_req_ready_c = winner_c;
                    addr_d         = winner_c ? bus.m1_req_addr : bus.m0_req_addr;
                    len_d          = winner_c ? bus.m1_req_len  : bus.m0_req_len;
                    size_d         = winner_c ? bus.m1_req_size : bus.m0_req_size;
                    owner_d        = winner_c;
                    last_grant_d   = winner_c;
                    state_d        = REQ;
                end
            end
            REQ: begin
                rd_req_valid_c = 1'b1;
                if (bus.rd_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.rd_resp_valid) begin
                    m0_rsp_valid_c = ~owner_q;
                    m1_rsp_valid_c = owner_q;
                    if (bus.rd_resp_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
        end
    end

    assign rsp_data_c       = bus.rd_resp_data;
    assign bus.rsp_data     = rsp_data_c;
    assign bus.rsp_resp     = bus.rd_resp_resp;
    assign bus.rsp_last     = bus.rd_resp_last;
    assign bus.m0_req_ready = m0_req_ready_c;
    assign bus.m1_req_ready = m1_req_ready_c;
    assign bus.m0_rsp_valid = m0_rsp_valid_c;
    assign bus.m1_rsp_valid = m1_rsp_valid_c;
    assign bus.rd_req_valid = rd_req_valid_c;
    assign bus.rd_id        = ID_W'(owner_q);
    assign bus.rd_addr      = addr_q;
    assign bus.rd_len       = len_q;
    assign bus.rd_size      = size_q;
endmodule

// File: tb/tb_ysyx_22041071_axi_r_arb.sv
// Scoreboard bench for the two-port read arbiter: a transaction-level model predicts grants,
// read requests and routed beats; a negedge monitor compares the DUT against the queues.
module tb_ysyx_22041071_axi_r_arb;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned ID_W   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [1:0]        size;
    } req_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        req_t            r;
    } rd_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    typedef enum {M_IDLE, M_REQ, M_DATA} mphase_e;

    logic clk = 1'b0;
    logic reset;

    ysyx_22041071_axi_r_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

    ysyx_22041071_axi_r_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control vector layout: {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, rd_req_valid}
    logic [4:0] exp_q[$];
    rd_t        req_q[$];
    beat_t      rsp_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Requester state and reference model state.
    bit      pend[2];
    req_t    preq[2];
    mphase_e phase;
    bit      last_g;
    bit      own;
    req_t    cur;
    int      beats_left;

    // Drive one clock cycle of stimulus, predict the DUT response, advance the model.
    task automatic cycle(input bit rst, input bit rdy, input bit beat, input logic [DATA_W-1:0] data);
        logic [4:0] e;
        bit         w, v0, v1, lst;
        logic [1:0] resp;
        e    = '0;
        v0   = pend[0] && !rst;
        v1   = pend[1] && !rst;
        resp = 2'($urandom_range(0, 3));
        lst  = (phase == M_DATA) ? (beats_left == 0) : 1'($urandom_range(0, 1));
        reset             = rst;
        bus.m0_req_valid  = v0;
        bus.m0_req_addr   = preq[0].addr;
        bus.m0_req_len    = preq[0].len;
        bus.m0_req_size   = preq[0].size;
        bus.m1_req_valid  = v1;
        bus.m1_req_addr   = preq[1].addr;
        bus.m1_req_len    = preq[1].len;
        bus.m1_req_size   = preq[1].size;
        bus.rd_req_ready  = rdy && !rst;
        bus.rd_resp_valid = beat && !rst;
        bus.rd_resp_data  = data;
        bus.rd_resp_resp  = resp;
        bus.rd_resp_last  = lst;
        case (phase)
            M_IDLE: begin
                if (v0 || v1) begin
                    w      = (v0 && v1) ? !last_g : v1;
                    e[w ? 3 : 4] = 1'b1;
                    cur    = preq[w];
                    own    = w;
                    last_g = w;
                    pend[w] = 1'b0;
                    phase  = M_REQ;
                end
            end
            M_REQ: begin
                e[0] = 1'b1;
                req_q.push_back({ID_W'(own), cur});
                if (rdy && !rst) begin
                    phase      = M_DATA;
                    beats_left = int'(cur.len);
                end
            end
            default: begin
                if (beat && !rst) begin
                    e[own ? 1 : 2] = 1'b1;
                    rsp_q.push_back({data, resp, lst});
                    if (lst) phase = M_IDLE;
                    else beats_left--;
                end
            end
        endcase
        exp_q.push_back(e);
        if (rst) begin
            phase   = M_IDLE;
            last_g  = 1'b1;
            own     = 1'b0;
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int p, input int max_len);
        pend[p]      = 1'b1;
        preq[p].addr = {$urandom, $urandom};
        preq[p].len  = LEN_W'($urandom_range(0, max_len));
        preq[p].size = 2'($urandom_range(0, 3));
    endtask

    task automatic run_random(input int n, input int p_req, input int p_rdy, input int p_beat);
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && int'($urandom_range(0, 99)) < p_req) new_req(p, 4);
            end
            cycle(1'b0, int'($urandom_range(0, 99)) < p_rdy, int'($urandom_range(0, 99)) < p_beat,
                  {$urandom, $urandom});
        end
    endtask

    task automatic drain();
        for (int g = 0; g < 300 && (phase != M_IDLE || pend[0] || pend[1]); g++) begin
            cycle(1'b0, 1'b1, 1'b1, {$urandom, $urandom});
        end
    endtask

    task automatic chk_rd_zero(input string name);
        n_vec++;
        if ({bus.rd_req_valid, bus.rd_id, bus.rd_addr, bus.rd_len, bus.rd_size} !== '0) begin
            n_err++;
            $display("FAIL %s: rd_req_valid=%b rd_id=%h rd_addr=%h rd_len=%h rd_size=%b, required all zero",
                     name, bus.rd_req_valid, bus.rd_id, bus.rd_addr, bus.rd_len, bus.rd_size);
        end
    endtask

    logic [4:0] m_act, m_exp;
    rd_t        m_ra, m_re;
    beat_t      m_ba, m_be;

    // Monitor: per-cycle control check plus payload checks whenever the DUT presents a request or beat.
    always @(negedge clk) begin
        if (mon_en) begin
            m_act = {bus.m0_req_ready, bus.m1_req_ready, bus.m0_rsp_valid, bus.m1_rsp_valid, bus.rd_req_valid};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ctl @%0t: got %b, required an expectation", $time, m_act);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_act !== m_exp) begin
                    n_err++;
                    $display("FAIL ctl @%0t: got %b required %b (m0rdy m1rdy m0rsp m1rsp rdv)", $time, m_act, m_exp);
                end
            end
            if (bus.rd_req_valid === 1'b1) begin
                n_vec++;
                m_ra = {bus.rd_id, bus.rd_addr, bus.rd_len, bus.rd_size};
                if (req_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_req @%0t: got %h, required none", $time, m_ra);
                end else begin
                    m_re = req_q.pop_front();
                    if (m_ra !== m_re) begin
                        n_err++;
                        $display("FAIL rd_req @%0t: got id/addr/len/size %h required %h", $time, m_ra, m_re);
                    end
                end
            end
            if (bus.m0_rsp_valid === 1'b1 || bus.m1_rsp_valid === 1'b1) begin
                n_vec++;
                m_ba = {bus.rsp_data, bus.rsp_resp, bus.rsp_last};
                if (rsp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp @%0t: got %h, required none", $time, m_ba);
                end else begin
                    m_be = rsp_q.pop_front();
                    if (m_ba !== m_be) begin
                        n_err++;
                        $display("FAIL rsp @%0t: got data/resp/last %h required %h", $time, m_ba, m_be);
                    end
                end
            end
        end
    end

    initial begin
        reset             = 1'b1;
        bus.m0_req_valid  = 1'b0;
        bus.m0_req_addr   = '0;
        bus.m0_req_len    = '0;
        bus.m0_req_size   = '0;
        bus.m1_req_valid  = 1'b0;
        bus.m1_req_addr   = '0;
        bus.m1_req_len    = '0;
        bus.m1_req_size   = '0;
        bus.rd_req_ready  = 1'b0;
        bus.rd_resp_valid = 1'b0;
        bus.rd_resp_last  = 1'b0;
        bus.rd_resp_data  = '0;
        bus.rd_resp_resp  = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        preq[0] = '0;
        preq[1] = '0;
        phase   = M_IDLE;
        last_g  = 1'b1;
        own     = 1'b0;
        cur     = '0;
        beats_left = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_rd_zero("reset_rd");
        mon_en = 1'b1;

        // Both ports hold requests continuously: strict alternation starting with port 0.
        run_random(40, 100, 100, 100);
        drain();

        // Single port 0 read, handshake two cycles after rd_req_valid rises.
        pend[0] = 1'b1;
        preq[0] = '{addr: 64'h8000_0000, len: '0, size: 2'b11};
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 64'h1122_3344_5566_7788);

        // Port 1 four-beat burst with random gaps.
        pend[1] = 1'b1;
        preq[1] = '{addr: {$urandom, $urandom}, len: 8'd3, size: 2'b10};
        run_random(40, 0, 50, 50);
        drain();

        // Port 0 raises its request while port 1 is receiving data.
        pend[1] = 1'b1;
        preq[1] = '{addr: {$urandom, $urandom}, len: 8'd2, size: 2'b01};
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        new_req(0, 2);
        cycle(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        cycle(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        cycle(1'b0, 1'b0, 1'b0, '0);
        drain();

        // Stray read-master beats while idle and while the request is pending.
        cycle(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        new_req(0, 1);
        cycle(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        cycle(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        cycle(1'b0, 1'b1, 1'b1, {$urandom, $urandom});
        drain();

        // Reset while the read request is stalled, then a lone port 1 request.
        new_req(0, 3);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk_rd_zero("mid_reset_rd");
        new_req(1, 3);
        cycle(1'b0, 1'b0, 1'b0, '0);
        drain();

        // Reset again, then a tie must go to port 0.
        new_req(1, 3);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk_rd_zero("mid_reset_rd2");
        new_req(0, 3);
        new_req(1, 3);
        cycle(1'b0, 1'b0, 1'b0, '0);
        drain();

        run_random(2000, 30, 60, 70);
        drain();

        mon_en = 1'b0;
        n_vec++;
        if (exp_q.size() != 0 || req_q.size() != 0 || rsp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: ctl=%0d req=%0d rsp=%0d entries unconsumed, required 0",
                     exp_q.size(), req_q.size(), rsp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
